// File: rtl/dmem_initiator_pkg.sv
// dmem_initiator_pkg: shared types and codes for the data-memory initiator.
//   - FSM state encoding
//   - sign_mask size codes (byte / half / word)
//   - rsp_err codes
//   - the few rv32i constants the memory path relies on
package dmem_initiator_pkg;

  // rv32i basics
  localparam int         XLEN      = 32;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STROBE  = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

  // sign_mask[2:0] size codes; sign_mask[3] selects sign extension
  localparam logic [2:0] SZ_BYTE = 3'b001;
  localparam logic [2:0] SZ_HALF = 3'b011;
  localparam logic [2:0] SZ_WORD = 3'b111;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

endpackage

// File: rtl/dmem_initiator_if.sv
// dmem_initiator_if: pipeline-request / memory-responder signal bundle.
//   master : the initiator (consumes req_*, mem_clk_stall, mem_read_data;
//            drives req_ready, mem_*, rsp_*)
//   slave  : the environment (pipeline + memory responder), opposite directions
interface dmem_initiator_if #(
  parameter int ADDR_W = 32
);
  import dmem_initiator_pkg::*;

  // pipeline request side
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [3:0]        req_sign_mask;
  // memory responder side
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_write_data;
  logic [3:0]        mem_sign_mask;
  logic              mem_memread;
  logic              mem_memwrite;
  logic              mem_clk_stall;
  logic [XLEN-1:0]   mem_read_data;
  // completion
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;
  logic [1:0]        rsp_err;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_sign_mask,
    input  mem_clk_stall, mem_read_data,
    output req_ready,
    output mem_addr, mem_write_data, mem_sign_mask, mem_memread, mem_memwrite,
    output rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_sign_mask,
    output mem_clk_stall, mem_read_data,
    input  req_ready,
    input  mem_addr, mem_write_data, mem_sign_mask, mem_memread, mem_memwrite,
    input  rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_initiator_align_check.sv
// dmem_align_check: combinational misalignment detector.
//   i_addr_lo     : byte address bits [1:0]
//   i_size        : sign_mask[2:0] size code
//   o_misaligned  : half on an odd address, or word not on a 4-byte boundary
// Unknown size codes are treated like bytes (never misaligned).
module dmem_align_check
  import dmem_initiator_pkg::*;
(
  input  logic [1:0] i_addr_lo,
  input  logic [2:0] i_size,
  output logic       o_misaligned
);

  always_comb begin
    o_misaligned = 1'b0;
    case (i_size)
      SZ_HALF: o_misaligned = i_addr_lo[0];
      SZ_WORD: o_misaligned = |i_addr_lo;
      default: o_misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_initiator.sv
// dmem_initiator: turns one pipeline load/store into a single-cycle strobe to
// a memory responder that signals busy via mem_clk_stall, then returns a
// one-cycle completion pulse.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : dmem_initiator_if.master (request, memory, response signals)
// Params: TIMEOUT_CYCLES - cycles allowed for stall to rise after the strobe
//         ADDR_W         - byte address width
module dmem_initiator
  import dmem_initiator_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  dmem_initiator_if.master         bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [3:0]        r_mask;
  logic              r_memread;
  logic              r_memwrite;
  logic              r_rsp_valid;
  logic [XLEN-1:0]   r_rdata;
  logic [1:0]        r_err;

  logic              w_ready;
  logic              w_accept;
  logic              w_misaligned;

  // A busy responder blocks acceptance even in IDLE, so a request offered
  // while stall is high stays with the pipeline.
  assign w_ready  = (r_state == ST_IDLE) && !bus.mem_clk_stall;
  assign w_accept = bus.req_valid && w_ready;

  dmem_align_check u_align (
    .i_addr_lo   (bus.req_addr[1:0]),
    .i_size      (bus.req_sign_mask[2:0]),
    .o_misaligned(w_misaligned)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_mask      <= '0;
      r_memread   <= 1'b0;
      r_memwrite  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_err       <= ERR_OK;
    end else begin
      // strobes and the completion pulse are single-cycle by default
      r_memread   <= 1'b0;
      r_memwrite  <= 1'b0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_mask  <= bus.req_sign_mask;
            r_write <= bus.req_write;
            r_rdata <= '0;
            if (w_misaligned) begin
              // reject without touching the memory
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_err       <= ERR_MISALIGN;
            end else begin
              r_state    <= ST_STROBE;
              r_memread  <= !bus.req_write;
              r_memwrite <= bus.req_write;
              r_err      <= ERR_OK;
            end
          end
        end
        ST_STROBE: begin
          r_state <= ST_WAIT_HI;
          r_cnt   <= '0;
        end
        ST_WAIT_HI: begin
          // a stall seen on the last allowed cycle still counts as in time
          if (bus.mem_clk_stall) begin
            r_state <= ST_WAIT_LO;
          end else if (r_cnt == CNT_LAST) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_err       <= ERR_TIMEOUT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_WAIT_LO: begin
          // once the responder has started, wait as long as it takes
          if (!bus.mem_clk_stall) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            if (!r_write) r_rdata <= bus.mem_read_data;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
          r_rdata <= '0;
          r_err   <= ERR_OK;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready      = w_ready;
  assign bus.mem_addr       = r_addr;
  assign bus.mem_write_data = r_wdata;
  assign bus.mem_sign_mask  = r_mask;
  assign bus.mem_memread    = r_memread;
  assign bus.mem_memwrite   = r_memwrite;
  assign bus.rsp_valid      = r_rsp_valid;
  assign bus.rsp_rdata      = r_rdata;
  assign bus.rsp_err        = r_err;

endmodule

// File: tb/tb_dmem_initiator.sv
// tb_dmem_initiator: directed bench for dmem_initiator.
// A timeline model predicts, per accepted request, the strobe cycle and the
// completion cycle from the responder's delay/hold settings; a compare process
// checks strobes, rsp_valid, req_ready, response fields and held mem_* values
// every cycle. Literal per-scenario expectations pin the model.
module tb_dmem_initiator;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_initiator_if #(.ADDR_W(32)) bus ();

  dmem_initiator #(.TIMEOUT_CYCLES(T), .ADDR_W(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_chk = 0, n_fail = 0;
  int cyc = 0;

  // model record of the current/last transaction (cycle numbers = posedge index)
  int          m_acc = -100, m_rsp = -100, m_kill = 1 << 30;
  bit          m_mis = 1'b0, m_write = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  logic [3:0]  m_mask = '0;
  logic [1:0]  m_err = '0;

  // responder behaviour: stall rises r_d cycles after it sees the strobe, held r_h cycles
  int r_d = 0, r_h = 2;
  bit r_never = 1'b0, r_force = 1'b0;
  int st_rise = -1, st_fall = -1;

  bit chk_en = 1'b0;
  int          obs_rv_cyc = -1;
  logic [31:0] obs_rdata = '0, obs_st_wdata = '0;
  logic [1:0]  obs_err = '0;
  logic [3:0]  obs_st_mask = '0;
  int          n_strobe = 0;
  int          strobe_q[$];
  logic [31:0] rv_q[$];

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h0000_1004) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // memory responder
  initial begin
    bus.mem_clk_stall = 1'b0;
    bus.mem_read_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_memread || bus.mem_memwrite) begin
        if (r_never) begin
          st_rise = -1; st_fall = -1;
        end else begin
          st_rise = cyc + 1 + r_d; st_fall = st_rise + r_h;
        end
      end
      bus.mem_clk_stall = r_force || (cyc >= st_rise && cyc < st_fall);
      bus.mem_read_data = (st_fall >= 0 && cyc >= st_fall) ? mem_val(bus.mem_addr) : 32'hBAD0_BAD0;
    end
  end

  // per-cycle compare against the model
  int c_n;
  bit c_live, c_strobe, c_busy, c_rv;
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      c_n      = cyc;
      c_live   = (c_n < m_kill);
      c_strobe = c_live && !m_mis && (c_n == m_acc);
      c_busy   = c_live && (c_n >= m_acc) && (c_n <= m_rsp);
      c_rv     = c_live && (c_n == m_rsp);
      chk("memread",   32'(bus.mem_memread),  32'(c_strobe && !m_write));
      chk("memwrite",  32'(bus.mem_memwrite), 32'(c_strobe && m_write));
      chk("rsp_valid", 32'(bus.rsp_valid),    32'(c_rv));
      chk("req_ready", 32'(bus.req_ready),    32'(!c_busy && !bus.mem_clk_stall));
      if (c_rv) begin
        chk("rsp_rdata", bus.rsp_rdata, m_rdata);
        chk("rsp_err",   32'(bus.rsp_err), 32'(m_err));
      end
      if (c_busy && !m_mis && c_n < m_rsp) begin
        chk("mem_addr",       bus.mem_addr, m_addr);
        chk("mem_write_data", bus.mem_write_data, m_wdata);
        chk("mem_sign_mask",  32'(bus.mem_sign_mask), 32'(m_mask));
      end
      if (bus.rsp_valid) begin
        obs_rv_cyc = c_n; obs_rdata = bus.rsp_rdata; obs_err = bus.rsp_err;
        rv_q.push_back(bus.rsp_rdata);
      end
      if (bus.mem_memread || bus.mem_memwrite) begin
        n_strobe++;
        strobe_q.push_back(c_n);
        obs_st_wdata = bus.mem_write_data; obs_st_mask = bus.mem_sign_mask;
      end
    end
  end

  // offer a request and hold it until accepted; fills the model record
  task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] mk);
    bit got;
    got = 1'b0;
    @(negedge clk); #1;
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = a;
    bus.req_wdata = wd;   bus.req_sign_mask = mk;
    for (int k = 0; k < 60 && !got; k++) begin
      if (bus.req_ready) begin
        got     = 1'b1;
        m_acc   = cyc + 1;
        m_mis   = (mk[2:0] == 3'b011 && a[0]) || (mk[2:0] == 3'b111 && a[1:0] != 2'b00);
        m_write = wr; m_addr = a; m_wdata = wd; m_mask = mk;
        m_rsp   = m_acc + (m_mis ? 0 : (r_never ? T + 1 : r_d + r_h + 2));
        m_err   = m_mis ? 2'b01 : (r_never ? 2'b10 : 2'b00);
        m_rdata = (m_mis || wr || r_never) ? 32'h0 : mem_val(a);
        m_kill  = 1 << 30;
        @(posedge clk); #2;
        bus.req_valid = 1'b0;
      end else begin
        @(negedge clk); #1;
      end
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout @cyc %0d: got no acceptance expected acceptance", cyc);
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    for (int k = 0; k < 100 && cyc <= m_rsp + 1; k++) @(negedge clk);
    n_chk++;
    if (cyc <= m_rsp + 1) begin
      n_fail++;
      $display("FAIL done_timeout @cyc %0d: got cyc %0d expected > %0d", cyc, cyc, m_rsp + 1);
    end
  endtask

  int n0, sq0, rq0, old_acc;

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_sign_mask = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_memread",   32'(bus.mem_memread), 32'd0);
    chk("rst_memwrite",  32'(bus.mem_memwrite), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_err",   32'(bus.rsp_err), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_mem_addr",  bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_write_data, 32'd0);
    chk("rst_mem_mask",  32'(bus.mem_sign_mask), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    rst_n = 1'b1; chk_en = 1'b1;

    // nominal load word, stall held two cycles
    r_d = 0; r_h = 2; n0 = n_strobe;
    do_req(1'b0, 32'h1004, 32'h0, 4'b0111); wait_done();
    chk("ldw_latency", 32'(obs_rv_cyc - m_acc), 32'd4);
    chk("ldw_rdata",   obs_rdata, 32'hDEAD_BEEF);
    chk("ldw_err",     32'(obs_err), 32'd0);
    chk("ldw_strobes", 32'(n_strobe - n0), 32'd1);

    // store byte
    n0 = n_strobe;
    do_req(1'b1, 32'h1003, 32'h0000_00A5, 4'b0001); wait_done();
    chk("stb_wdata",   obs_st_wdata, 32'h0000_00A5);
    chk("stb_mask",    32'(obs_st_mask), 32'h1);
    chk("stb_rdata",   obs_rdata, 32'h0);
    chk("stb_err",     32'(obs_err), 32'd0);
    chk("stb_strobes", 32'(n_strobe - n0), 32'd1);

    // misaligned half and word: immediate error, no strobe
    n0 = n_strobe;
    do_req(1'b0, 32'h1001, 32'h0, 4'b1011); wait_done();
    chk("mish_latency", 32'(obs_rv_cyc - m_acc), 32'd0);
    chk("mish_err",     32'(obs_err), 32'd1);
    do_req(1'b1, 32'h1002, 32'h1234_5678, 4'b0111); wait_done();
    chk("misw_err",     32'(obs_err), 32'd1);
    chk("mis_strobes",  32'(n_strobe - n0), 32'd0);

    // aligned half with delayed, longer stall
    r_d = 1; r_h = 3;
    do_req(1'b0, 32'h1002, 32'h0, 4'b1011); wait_done();
    chk("ldh_latency", 32'(obs_rv_cyc - m_acc), 32'd6);
    chk("ldh_rdata",   obs_rdata, 32'h5A5A_1002);

    // stall rises exactly on the last allowed cycle: still a normal completion
    r_d = T - 1; r_h = 1;
    do_req(1'b0, 32'h2010, 32'h0, 4'b0111); wait_done();
    chk("late_latency", 32'(obs_rv_cyc - m_acc), 32'd6);
    chk("late_err",     32'(obs_err), 32'd0);

    // responder never answers: timeout
    r_never = 1'b1;
    do_req(1'b0, 32'h2000, 32'h0, 4'b0111); wait_done();
    chk("to_latency", 32'(obs_rv_cyc - m_acc), 32'd5);
    chk("to_err",     32'(obs_err), 32'd2);
    chk("to_rdata",   obs_rdata, 32'h0);
    r_never = 1'b0;

    // back-to-back loads
    r_d = 0; r_h = 2; sq0 = strobe_q.size(); rq0 = rv_q.size();
    do_req(1'b0, 32'h3000, 32'h0, 4'b0111);
    do_req(1'b0, 32'h3004, 32'h0, 4'b0111);
    wait_done();
    if (strobe_q.size() >= sq0 + 2 && rv_q.size() >= rq0 + 2) begin
      chk("b2b_gap_min", 32'(strobe_q[sq0+1] - strobe_q[sq0] >= 5), 32'd1);
      chk("b2b_gap",     32'(strobe_q[sq0+1] - strobe_q[sq0]), 32'd6);
      chk("b2b_rsp0",    rv_q[rq0],   32'h5A5A_3000);
      chk("b2b_rsp1",    rv_q[rq0+1], 32'h5A5A_3004);
    end else begin
      n_chk++; n_fail++;
      $display("FAIL b2b_count: got %0d strobes expected 2", strobe_q.size() - sq0);
    end

    // reset during WAIT_LO with the responder still busy
    r_d = 0; r_h = 10; rq0 = rv_q.size();
    do_req(1'b0, 32'h4000, 32'h0, 4'b0111);
    old_acc = m_acc;
    while (cyc < old_acc + 3) @(negedge clk);
    #1;
    m_kill = cyc + 1;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    r_h = 2;
    do_req(1'b0, 32'h4008, 32'h0, 4'b0111);
    chk("rst_no_rsp",       32'(rv_q.size() - rq0), 32'd0);
    chk("rst_accept_cycle", 32'(m_acc - old_acc), 32'd12);
    wait_done();
    chk("rst_next_rdata", obs_rdata, 32'h5A5A_4008);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected end before 200000");
    $fatal(1, "watchdog");
  end

endmodule
